// File: rtl/ai_accel_ahb.sv
// rtl/ai_accel_ahb.sv - AHB-Lite subordinate for an 8x8 int8 matrix-multiply engine, O = act(X*W + B)
// Every accepted transfer takes at least one wait state. Read data and error responses are therefore registered.
module ai_accel_ahb #(
   parameter int N      = 8,
   parameter int W_BASE = 0
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        hsel,
   input  logic [9:0]  haddr,
   input  logic [1:0]  htrans,
   input  logic [1:0]  hsize,
   input  logic        hwrite,
   input  logic [63:0] hwdata,
   input  logic        hburst,
   output logic [63:0] hrdata,
   output logic        hresp,
   output logic        hready,
   output logic [9:0]  address,
   output logic        read_enable,
   output logic        write_enable,
   output logic [31:0] write_data,
   input  logic [31:0] read_data,
   input  logic [1:0]  sram_state
);
   localparam logic [1:0] SRAM_FREE = 2'd0;
   localparam logic [1:0] SRAM_ERR  = 2'd3;

   typedef enum logic [2:0] {IDLE, DATA, S_ISSUE, S_STROBE, S_WAIT, ERR} state_t;
   typedef enum logic [2:0] {R_W, R_X, R_B, R_O, R_STAT, R_WCTL, R_START, R_ACT} region_t;

   state_t  state;
   region_t a_region, ph_region;
   logic    a_err, ph_err, ph_write;
   logic [7:0]  a_mask, ph_mask;
   logic [2:0]  ph_low;
   logic [63:0] x_mem [N];
   logic [63:0] b_mem [N];
   logic [63:0] w_mem [N];
   logic [63:0] o_mem [N];
   logic [63:0] wbuf, bit_mask, rd_val;
   logic [7:0]  byte_in, reg_byte, status;
   logic [3:0]  cnt;
   logic [1:0]  act;
   logic        load_mode, w_loaded, err_flag, start_pulse, busy, done, busy_any, stall;
   logic [9:0]  sram_addr;
   logic        accept;
   logic        unused;

   assign unused   = ^{hburst, htrans[0]};
   assign accept   = hsel & htrans[1] & hready;
   assign busy_any = busy | start_pulse;
   assign status   = {4'd0, err_flag, w_loaded, done, busy};
   assign byte_in  = hwdata[{ph_low, 3'b000} +: 8];
   assign sram_addr = 10'(W_BASE) + (load_mode ? {6'd0, cnt} : {6'd0, ph_low, cnt[0]});

   always_comb begin
      a_region = R_STAT;
      a_err    = 1'b0;
      if (haddr[9:5] == 5'd0) begin
         case (haddr[4:3])
            2'd0:    begin a_region = R_W; a_err = !hwrite; end
            2'd1:    a_region = R_X;
            2'd2:    a_region = R_B;
            default: begin a_region = R_O; a_err = hwrite; end
         endcase
      end else if (haddr[9:3] == 7'h04) begin
         case (haddr[2:0])
            3'd0:    begin a_region = R_STAT;  a_err = hwrite;  end
            3'd2:    begin a_region = R_WCTL;  a_err = !hwrite; end
            3'd3:    begin a_region = R_START; a_err = !hwrite; end
            3'd4:    a_region = R_ACT;
            default: a_err = 1'b1;
         endcase
      end else begin
         a_err = 1'b1;
      end
   end

   // Byte lanes enabled by a narrow transfer, aligned to its size within the 64-bit register.
   always_comb begin
      case (hsize)
         2'd0:    a_mask = 8'h01 << haddr[2:0];
         2'd1:    a_mask = 8'h03 << {haddr[2:1], 1'b0};
         2'd2:    a_mask = 8'h0F << {haddr[2], 2'b00};
         default: a_mask = 8'hFF;
      endcase
   end

   always_comb begin
      bit_mask = '0;
      for (int i = 0; i < 8; i++) bit_mask[8*i +: 8] = {8{ph_mask[i]}};
   end

   always_comb begin
      stall = 1'b0;
      if (busy_any) begin
         if (ph_write) stall = (ph_region inside {R_W, R_X, R_B, R_WCTL, R_ACT});
         else          stall = (ph_region == R_O);
      end
   end

   always_comb begin
      rd_val   = '0;
      reg_byte = '0;
      case (ph_region)
         R_X:     rd_val = x_mem[ph_low];
         R_B:     rd_val = b_mem[ph_low];
         R_O:     rd_val = o_mem[ph_low];
         R_STAT:  reg_byte = status;
         R_ACT:   reg_byte = {6'd0, act};
         default: ;
      endcase
      if (ph_region == R_STAT || ph_region == R_ACT) rd_val = 64'(reg_byte) << {ph_low, 3'b000};
   end

   always_ff @(posedge clk or posedge n_rst) begin
      if (n_rst) begin
         state <= IDLE;
         hready <= 1'b1;
         hresp <= 1'b0;
         hrdata <= '0;
         address <= '0;
         read_enable <= 1'b0;
         write_enable <= 1'b0;
         write_data <= '0;
         ph_region <= R_STAT;
         ph_err <= 1'b0;
         ph_write <= 1'b0;
         ph_mask <= '0;
         ph_low <= '0;
         wbuf <= '0;
         cnt <= '0;
         act <= '0;
         load_mode <= 1'b0;
         w_loaded <= 1'b0;
         err_flag <= 1'b0;
         start_pulse <= 1'b0;
         for (int i = 0; i < N; i++) begin
            x_mem[i] <= '0;
            b_mem[i] <= '0;
            w_mem[i] <= '0;
         end
      end else begin
         start_pulse <= 1'b0;
         case (state)
            IDLE: begin
               hresp <= 1'b0;
               if (accept) begin
                  ph_region <= a_region;
                  ph_err <= a_err;
                  ph_write <= hwrite;
                  ph_mask <= a_mask;
                  ph_low <= haddr[2:0];
                  hready <= 1'b0;
                  state <= DATA;
               end
            end
            DATA: begin
               if (ph_err) begin
                  hresp <= 1'b1;
                  state <= ERR;
               end else if (!stall) begin
                  hready <= 1'b1;
                  state <= IDLE;
                  if (ph_write) begin
                     case (ph_region)
                        R_W: begin
                           wbuf <= hwdata;
                           cnt <= '0;
                           load_mode <= 1'b0;
                           hready <= 1'b0;
                           state <= S_ISSUE;
                        end
                        R_X: x_mem[ph_low] <= (x_mem[ph_low] & ~bit_mask) | (hwdata & bit_mask);
                        R_B: b_mem[ph_low] <= (b_mem[ph_low] & ~bit_mask) | (hwdata & bit_mask);
                        R_WCTL: if (byte_in == 8'h02) begin
                           cnt <= '0;
                           load_mode <= 1'b1;
                           hready <= 1'b0;
                           state <= S_ISSUE;
                        end
                        R_START: if (byte_in[0] && !busy_any) start_pulse <= 1'b1;
                        R_ACT: act <= byte_in[1:0];
                        default: ;
                     endcase
                  end else begin
                     hrdata <= rd_val;
                  end
               end
            end
            S_ISSUE: begin
               if (sram_state == SRAM_ERR) begin
                  err_flag <= 1'b1;
                  hresp <= 1'b1;
                  state <= ERR;
               end else if (sram_state == SRAM_FREE) begin
                  address <= sram_addr;
                  read_enable <= load_mode;
                  write_enable <= !load_mode;
                  write_data <= cnt[0] ? wbuf[63:32] : wbuf[31:0];
                  state <= S_STROBE;
               end
            end
            S_STROBE: begin
               read_enable <= 1'b0;
               write_enable <= 1'b0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (sram_state == SRAM_ERR) begin
                  err_flag <= 1'b1;
                  hresp <= 1'b1;
                  state <= ERR;
               end else if (sram_state == SRAM_FREE) begin
                  if (load_mode) w_mem[cnt[3:1]][{cnt[0], 5'b00000} +: 32] <= read_data;
                  if (cnt == (load_mode ? 4'd15 : 4'd1)) begin
                     if (load_mode) w_loaded <= 1'b1;
                     hready <= 1'b1;
                     state <= IDLE;
                  end else begin
                     cnt <= cnt + 4'd1;
                     state <= S_ISSUE;
                  end
               end
            end
            ERR: begin
               hready <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Compute: one output row at a time, eight column MACs each consuming one k per cycle.
   logic [2:0]         r_idx, k_idx;
   logic signed [19:0] acc [N];
   logic signed [7:0]  x_k;
   logic signed [7:0]  w_kc [N];
   logic signed [15:0] prod [N];
   logic signed [19:0] acc_next [N];
   logic signed [19:0] pre_act [N];

   function automatic logic [7:0] activate(input logic signed [19:0] v, input logic [1:0] mode);
      logic signed [19:0] t;
      t = v;
      if ((mode == 2'd1 || mode == 2'd2) && t < 0) t = '0;
      if (mode == 2'd2 && t > 20'sd127) t = 20'sd127;
      if (t > 20'sd127) return 8'h7F;
      if (t < -20'sd128) return 8'h80;
      return t[7:0];
   endfunction

   always_comb begin
      x_k = x_mem[r_idx][8*k_idx +: 8];
      for (int c = 0; c < N; c++) begin
         w_kc[c] = w_mem[k_idx][8*c +: 8];
         prod[c] = x_k * w_kc[c];
         acc_next[c] = acc[c] + {{4{prod[c][15]}}, prod[c]};
         pre_act[c] = acc_next[c] + {{12{b_mem[r_idx][8*c+7]}}, b_mem[r_idx][8*c +: 8]};
      end
   end

   always_ff @(posedge clk or posedge n_rst) begin
      if (n_rst) begin
         busy <= 1'b0;
         done <= 1'b0;
         r_idx <= '0;
         k_idx <= '0;
         for (int i = 0; i < N; i++) begin
            acc[i] <= '0;
            o_mem[i] <= '0;
         end
      end else if (start_pulse && !busy) begin
         busy <= 1'b1;
         done <= 1'b0;
         r_idx <= '0;
         k_idx <= '0;
         for (int c = 0; c < N; c++) acc[c] <= '0;
      end else if (busy) begin
         k_idx <= k_idx + 3'd1;
         if (k_idx == 3'(N - 1)) begin
            for (int c = 0; c < N; c++) begin
               o_mem[r_idx][8*c +: 8] <= activate(pre_act[c], act);
               acc[c] <= '0;
            end
            r_idx <= r_idx + 3'd1;
            if (r_idx == 3'(N - 1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end else begin
            for (int c = 0; c < N; c++) acc[c] <= acc_next[c];
         end
      end
   end
endmodule

// File: tb/tb_ai_accel_ahb.sv
// tb/tb_ai_accel_ahb.sv - randomized self-checking bench for ai_accel_ahb with an SRAM model
// The reference model computes O from row arrays with plain integer arithmetic.
module tb_ai_accel_ahb;
   logic        clk = 1'b0;
   logic        n_rst = 1'b1;
   logic        hsel = 1'b0;
   logic [9:0]  haddr = '0;
   logic [1:0]  htrans = '0;
   logic [1:0]  hsize = '0;
   logic        hwrite = 1'b0;
   logic [63:0] hwdata = '0;
   logic        hburst = 1'b0;
   logic [63:0] hrdata;
   logic        hresp, hready;
   logic [9:0]  address;
   logic        read_enable, write_enable;
   logic [31:0] write_data;
   logic [31:0] read_data = '0;
   logic [1:0]  sram_state = 2'd0;

   always #5 clk = ~clk;

   ai_accel_ahb dut (
      .clk(clk), .n_rst(n_rst), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hsize(hsize),
      .hwrite(hwrite), .hwdata(hwdata), .hburst(hburst), .hrdata(hrdata), .hresp(hresp),
      .hready(hready), .address(address), .read_enable(read_enable), .write_enable(write_enable),
      .write_data(write_data), .read_data(read_data), .sram_state(sram_state)
   );

   int errors = 0;
   int checks = 0;

   // SRAM model: strobe accepted only while FREE, then BUSY for 1-3 cycles, ACCESS, FREE.
   logic [31:0] mem [1024];
   logic        mem_init = 1'b0;
   logic        force_err = 1'b0;
   logic        pend_we = 1'b0;
   logic [9:0]  pend_a = '0;
   logic [31:0] pend_d = '0;
   int          lat = 0;
   int          strobe_viol = 0;
   logic [9:0]  log_a [$];
   logic [31:0] log_d [$];

   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 1024; i++) mem[i] <= '0;
         mem_init <= 1'b1;
      end
      if ((write_enable || read_enable) && sram_state != 2'd0 && !force_err) strobe_viol <= strobe_viol + 1;
      if (force_err) sram_state <= 2'd3;
      else begin
         case (sram_state)
            2'd0: if (write_enable || read_enable) begin
               pend_we <= write_enable;
               pend_a <= address;
               pend_d <= write_data;
               lat <= $urandom_range(1, 3);
               sram_state <= 2'd1;
            end
            2'd1: if (lat <= 1) sram_state <= 2'd2; else lat <= lat - 1;
            2'd2: begin
               if (pend_we) begin
                  mem[pend_a] <= pend_d;
                  log_a.push_back(pend_a);
                  log_d.push_back(pend_d);
               end else read_data <= mem[pend_a];
               sram_state <= 2'd0;
            end
            default: sram_state <= 2'd0;
         endcase
      end
   end

   logic [63:0] xr [8];
   logic [63:0] br [8];
   logic [63:0] w_st [8];
   logic [63:0] w_ld [8];
   logic [63:0] ro [8];
   logic [63:0] got [8];
   int          actv = 0;

   logic [63:0] rd;
   logic        rsp_err, err_shape;
   int          waits;

   function automatic logic [63:0] model_row(input int r);
      logic [63:0] res;
      int s;
      byte xb, wb, bb;
      res = '0;
      for (int c = 0; c < 8; c++) begin
         bb = br[r][8*c +: 8];
         s = bb;
         for (int k = 0; k < 8; k++) begin
            xb = xr[r][8*k +: 8];
            wb = w_ld[k][8*c +: 8];
            s += xb * wb;
         end
         if (actv != 0 && s < 0) s = 0;
         if (actv == 2 && s > 127) s = 127;
         if (s > 127) s = 127;
         if (s < -128) s = -128;
         res[8*c +: 8] = s[7:0];
      end
      return res;
   endfunction

   task automatic xfer(input logic wr, input logic [9:0] a, input logic [1:0] sz, input logic [63:0] wd);
      int n;
      logic prev_err;
      hsel = 1'b1; haddr = a; htrans = 2'd2; hsize = sz; hwrite = wr; hburst = 1'b0;
      n = 0;
      forever begin
         @(negedge clk);
         if (hready) break;
         n++;
         if (n > 3000) begin
            checks++; errors++;
            $display("FAIL addr_phase_timeout addr=%h", a);
            break;
         end
      end
      @(posedge clk); #1;
      hsel = 1'b0; htrans = 2'd0; hwdata = wd;
      waits = 0; prev_err = 1'b0; err_shape = 1'b0; rsp_err = 1'b0;
      forever begin
         @(negedge clk);
         if (hready) begin
            rsp_err = hresp;
            rd = hrdata;
            err_shape = hresp && prev_err;
            break;
         end
         prev_err = hresp;
         waits++;
         if (waits > 3000) begin
            checks++; errors++;
            $display("FAIL data_phase_timeout addr=%h", a);
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic wr_byte(input logic [9:0] a, input logic [7:0] v);
      xfer(1'b1, a, 2'd0, 64'(v) << {a[2:0], 3'b000});
   endtask

   task automatic put_w(input int r, input logic [63:0] d);
      xfer(1'b1, 10'(r), 2'd3, d); w_st[r] = d;
   endtask

   task automatic put_x(input int r, input logic [63:0] d);
      xfer(1'b1, 10'(8 + r), 2'd3, d); xr[r] = d;
   endtask

   task automatic put_b(input int r, input logic [63:0] d);
      xfer(1'b1, 10'(16 + r), 2'd3, d); br[r] = d;
   endtask

   task automatic set_act(input int v);
      wr_byte(10'h24, 8'(v)); actv = v;
   endtask

   task automatic do_load();
      wr_byte(10'h22, 8'h02);
      for (int r = 0; r < 8; r++) w_ld[r] = w_st[r];
   endtask

   task automatic do_start();
      wr_byte(10'h23, 8'h01);
      for (int r = 0; r < 8; r++) ro[r] = model_row(r);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      do begin
         xfer(1'b0, 10'h20, 2'd0, '0);
         n++;
      end while (!rd[1] && n < 200);
      checks++;
      if (!rd[1]) begin errors++; $display("FAIL done_poll status=%h required b1=1", rd[7:0]); end
   endtask

   task automatic read_o();
      for (int r = 0; r < 8; r++) begin
         xfer(1'b0, 10'(24 + r), 2'd3, '0);
         got[r] = rd;
      end
   endtask

   task automatic test_reset();
      n_rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (hready !== 1'b1) begin errors++; $display("FAIL rst_hready got=%b exp=1", hready); end
      checks++; if (hresp !== 1'b0) begin errors++; $display("FAIL rst_hresp got=%b exp=0", hresp); end
      checks++; if (hrdata !== 64'd0) begin errors++; $display("FAIL rst_hrdata got=%h exp=0", hrdata); end
      checks++;
      if ({read_enable, write_enable, address, write_data} !== 44'd0) begin
         errors++; $display("FAIL rst_sram_port got=%b%b %h %h exp=0", read_enable, write_enable, address, write_data);
      end
      n_rst = 1'b0;
      @(posedge clk); #1;
      for (int r = 0; r < 8; r++) begin xr[r] = '0; br[r] = '0; w_st[r] = '0; w_ld[r] = '0; ro[r] = '0; end
      actv = 0;
      xfer(1'b0, 10'h20, 2'd0, '0);
      checks++; if (rd[7:0] !== 8'h00) begin errors++; $display("FAIL rst_status got=%h exp=00", rd[7:0]); end
      read_o();
      for (int r = 0; r < 8; r++) begin
         checks++; if (got[r] !== 64'd0) begin errors++; $display("FAIL rst_o_row%0d got=%h exp=0", r, got[r]); end
      end
   endtask

   task automatic test_basic();
      for (int r = 0; r < 8; r++) begin
         put_w(r, {8{8'h01}});
         put_x(r, {8{8'h01}});
         put_b(r, {8{8'h01}});
      end
      set_act(2);
      do_load();
      xfer(1'b0, 10'h20, 2'd0, '0);
      checks++; if (rd[2] !== 1'b1) begin errors++; $display("FAIL basic_wloaded status=%h exp b2=1", rd[7:0]); end
      do_start();
      wait_done();
      checks++; if (rd[7:0] !== 8'h06) begin errors++; $display("FAIL basic_status_done got=%h exp=06", rd[7:0]); end
      read_o();
      for (int r = 0; r < 8; r++) begin
         checks++;
         if (got[r] !== 64'h0909_0909_0909_0909) begin
            errors++; $display("FAIL basic_o_row%0d got=%h exp=0909090909090909", r, got[r]);
         end
      end
   endtask

   task automatic test_busy_stall();
      logic [63:0] nw [8];
      for (int r = 0; r < 8; r++) nw[r] = {$urandom, $urandom};
      do_start();
      put_w(0, nw[0]);
      checks++; if (waits < 50) begin errors++; $display("FAIL stall_w_write waits got=%0d exp>=50", waits); end
      for (int r = 1; r < 8; r++) put_w(r, nw[r]);
      do_load();
      read_o();
      for (int r = 0; r < 8; r++) begin
         checks++;
         if (got[r] !== 64'h0909_0909_0909_0909) begin
            errors++; $display("FAIL stall_old_o_row%0d got=%h exp=0909090909090909", r, got[r]);
         end
      end
      do_start();
      wait_done();
      read_o();
      for (int r = 0; r < 8; r++) begin
         checks++; if (got[r] !== ro[r]) begin errors++; $display("FAIL stall_new_o_row%0d got=%h exp=%h", r, got[r], ro[r]); end
      end
   endtask

   task automatic test_w_row_sram();
      int r;
      logic [63:0] d;
      r = $urandom_range(0, 7);
      d = {$urandom, $urandom};
      log_a.delete(); log_d.delete();
      put_w(r, d);
      checks++; if (log_a.size() !== 2) begin errors++; $display("FAIL wrow_count got=%0d exp=2", log_a.size()); end
      if (log_a.size() == 2) begin
         checks++; if (log_a[0] !== 10'(2*r) || log_d[0] !== d[31:0]) begin
            errors++; $display("FAIL wrow_lo got=%h:%h exp=%h:%h", log_a[0], log_d[0], 10'(2*r), d[31:0]);
         end
         checks++; if (log_a[1] !== 10'(2*r+1) || log_d[1] !== d[63:32]) begin
            errors++; $display("FAIL wrow_hi got=%h:%h exp=%h:%h", log_a[1], log_d[1], 10'(2*r+1), d[63:32]);
         end
      end
      checks++; if (sram_state !== 2'd0) begin errors++; $display("FAIL wrow_free got=%0d exp=0", sram_state); end
      checks++; if (strobe_viol !== 0) begin errors++; $display("FAIL wrow_strobe_viol got=%0d exp=0", strobe_viol); end
   endtask

   task automatic test_narrow();
      xfer(1'b1, 10'h09, 2'd0, 64'hAB << 8);        xr[1][15:8] = 8'hAB;
      xfer(1'b1, 10'h0A, 2'd1, 64'hC0DE << 16);     xr[2][31:16] = 16'hC0DE;
      xfer(1'b1, 10'h0C, 2'd2, 64'h1234_5678 << 32); xr[4][63:32] = 32'h1234_5678;
      xfer(1'b1, 10'h17, 2'd0, 64'h5A << 56);       br[7][63:56] = 8'h5A;
      for (int r = 1; r < 5; r++) begin
         xfer(1'b0, 10'(8 + r), 2'd3, '0);
         checks++; if (rd !== xr[r]) begin errors++; $display("FAIL narrow_x_row%0d got=%h exp=%h", r, rd, xr[r]); end
      end
      xfer(1'b0, 10'h17, 2'd3, '0);
      checks++; if (rd !== br[7]) begin errors++; $display("FAIL narrow_b_row7 got=%h exp=%h", rd, br[7]); end
      xfer(1'b0, 10'h24, 2'd0, '0);
      checks++; if (rd[39:32] !== 8'(actv)) begin errors++; $display("FAIL act_readback got=%h exp=%h", rd[39:32], 8'(actv)); end
   endtask

   task automatic test_errors();
      xfer(1'b0, 10'h3FF, 2'd3, '0);
      checks++; if (!(rsp_err && err_shape)) begin errors++; $display("FAIL err_unmapped resp=%b shape=%b exp=1,1", rsp_err, err_shape); end
      xfer(1'b1, 10'h18, 2'd3, {$urandom, $urandom});
      checks++; if (!(rsp_err && err_shape)) begin errors++; $display("FAIL err_write_ro resp=%b shape=%b exp=1,1", rsp_err, err_shape); end
      xfer(1'b0, 10'h18, 2'd3, '0);
      checks++; if (rsp_err || rd !== ro[0]) begin errors++; $display("FAIL err_o_unchanged got=%h exp=%h", rd, ro[0]); end
      xfer(1'b0, 10'h22, 2'd0, '0);
      checks++; if (!(rsp_err && err_shape)) begin errors++; $display("FAIL err_read_wo resp=%b shape=%b exp=1,1", rsp_err, err_shape); end
      xfer(1'b0, 10'h20, 2'd0, '0);
      checks++; if (rd[3] !== 1'b0) begin errors++; $display("FAIL err_status_b3 got=%b exp=0", rd[3]); end
   endtask

   task automatic run_pattern(input logic [63:0] xv, input logic [63:0] wv, input int a, input logic [63:0] ev, input string tag);
      for (int r = 0; r < 8; r++) begin put_w(r, wv); put_x(r, xv); put_b(r, 64'd0); end
      set_act(a);
      do_load();
      do_start();
      wait_done();
      read_o();
      for (int r = 0; r < 8; r++) begin
         checks++; if (got[r] !== ev) begin errors++; $display("FAIL %s_row%0d got=%h exp=%h", tag, r, got[r], ev); end
      end
   endtask

   task automatic test_patterns();
      run_pattern({8{8'h7F}}, {8{8'h7F}}, 0, {8{8'h7F}}, "sat");
      run_pattern({8{8'h80}}, {8{8'h01}}, 1, {8{8'h00}}, "relu");
   endtask

   task automatic test_random();
      for (int it = 0; it < 3; it++) begin
         for (int r = 0; r < 8; r++) begin
            put_w(r, {$urandom, $urandom});
            put_x(r, {$urandom, $urandom});
            put_b(r, {$urandom, $urandom});
         end
         set_act($urandom_range(0, 2));
         do_load();
         do_start();
         wait_done();
         read_o();
         for (int r = 0; r < 8; r++) begin
            checks++; if (got[r] !== ro[r]) begin errors++; $display("FAIL rand%0d_row%0d got=%h exp=%h", it, r, got[r], ro[r]); end
         end
      end
   endtask

   task automatic test_sram_error();
      force_err = 1'b1;
      @(posedge clk); #1;
      xfer(1'b1, 10'h02, 2'd3, {$urandom, $urandom});
      checks++; if (!(rsp_err && err_shape)) begin errors++; $display("FAIL sram_err_resp resp=%b shape=%b exp=1,1", rsp_err, err_shape); end
      force_err = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      xfer(1'b0, 10'h20, 2'd0, '0);
      checks++; if (rd[3] !== 1'b1) begin errors++; $display("FAIL sram_err_status got=%h exp b3=1", rd[7:0]); end
   endtask

   task automatic test_reset_mid();
      do_start();
      repeat (5) @(posedge clk);
      #1;
      n_rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_rst = 1'b0;
      @(posedge clk); #1;
      xfer(1'b0, 10'h20, 2'd0, '0);
      checks++; if (rd[7:0] !== 8'h00) begin errors++; $display("FAIL midrst_status got=%h exp=00", rd[7:0]); end
      xfer(1'b0, 10'h1B, 2'd3, '0);
      checks++; if (rd !== 64'd0) begin errors++; $display("FAIL midrst_o_row3 got=%h exp=0", rd); end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog simulation time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_busy_stall();
      test_w_row_sram();
      test_narrow();
      test_errors();
      test_patterns();
      test_random();
      test_sram_error();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
